mul_unit: RTL and testbench

MUL_UNIT -- requirements
Module: mul_unit

---
 rtl/mul_unit_pkg.sv | 5 +
 rtl/mul_unit.sv | 73 +++++++
 tb/tb_mul_unit.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/mul_unit_pkg.sv
// mul_unit_pkg: shared processor constants for the multiply unit.
package mul_unit_pkg;
  localparam int MUL_WIDTH = 32;
  typedef enum logic [1:0] {IDLE, RUN, FIX} mul_state_t;
endpackage

// File: rtl/mul_unit.sv
// mul_unit: iterative shift-add multiplier owning the architectural HI/LO registers.
module mul_unit
  import mul_unit_pkg::*;
#(
  parameter int WIDTH = MUL_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             wr_hi,
  input  logic             wr_lo,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);
  mul_state_t         state;
  logic [5:0]         cnt;
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] mcand;
  logic [WIDTH-1:0]   mplier;
  logic               neg;
  logic [WIDTH-1:0]   mag_a;
  logic [WIDTH-1:0]   mag_b;
  logic [2*WIDTH-1:0] prod;
  // The most-negative value negates to itself, which is its correct unsigned magnitude.
  assign mag_a = (is_signed && a[WIDTH-1]) ? -a : a;
  assign mag_b = (is_signed && b[WIDTH-1]) ? -b : b;
  assign prod  = neg ? -acc : acc;
  assign busy  = state != IDLE;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      cnt    <= '0;
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      neg    <= 1'b0;
      done   <= 1'b0;
      hi     <= '0;
      lo     <= '0;
    end else begin
      done <= 1'b0;
      if (state == IDLE) begin
        if (start) begin
          state  <= RUN;
          cnt    <= '0;
          acc    <= '0;
          mcand  <= {{WIDTH{1'b0}}, mag_a};
          mplier <= mag_b;
          neg    <= is_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
        end
        if (wr_hi) hi <= wdata;
        if (wr_lo) lo <= wdata;
      end else if (state == RUN) begin
        acc    <= acc + (mplier[0] ? mcand : '0);
        mcand  <= mcand << 1;
        mplier <= mplier >> 1;
        cnt    <= cnt + 6'd1;
        if (cnt == 6'(WIDTH - 1)) state <= FIX;
      end else begin
        hi    <= prod[2*WIDTH-1:WIDTH];
        lo    <= prod[WIDTH-1:0];
        done  <= 1'b1;
        state <= IDLE;
      end
    end
  end
endmodule

// File: tb/tb_mul_unit.sv
// tb_mul_unit: randomized scoreboard bench for mul_unit against an arithmetic reference.
module tb_mul_unit;
  localparam int W = 32;
  logic clk = 0, reset = 1, start = 0, is_signed = 0, wr_hi = 0, wr_lo = 0;
  logic [W-1:0] a = 0, b = 0, wdata = 0;
  logic busy, done;
  logic [W-1:0] hi, lo;
  int cyc = 0, nchk = 0, nerr = 0;
  typedef struct {logic [63:0] prod; int due;} exp_t;
  exp_t q[$];

  mul_unit #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .start(start), .is_signed(is_signed), .a(a), .b(b),
    .wr_hi(wr_hi), .wr_lo(wr_lo), .wdata(wdata), .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  function automatic logic [63:0] model(bit sgn, logic [31:0] x, logic [31:0] y);
    longint p;
    if (sgn) p = longint'($signed(x)) * longint'($signed(y));
    else p = longint'({32'b0, x}) * longint'({32'b0, y});
    return p;
  endfunction

  function automatic logic [31:0] pick();
    int r = $urandom_range(0, 7);
    return r == 0 ? 32'h8000_0000 : r == 1 ? 32'hffff_ffff : r == 2 ? 32'h0 : r == 3 ? 32'h1 : $urandom;
  endfunction

  always @(negedge clk) begin : mon
    exp_t e;
    if (!reset && done) begin
      if (q.size() == 0) begin
        nchk++;
        nerr++;
        $display("FAIL spurious_done at cycle %0d: got done=1 expected done=0", cyc);
      end else begin
        e = q.pop_front();
        check("product", {hi, lo}, e.prod);
        check("done_cycle", 64'(cyc), 64'(e.due));
      end
    end
  end

  // call at a negedge; start is sampled at the following edge, done is due 33 edges later
  task automatic issue(bit sgn, logic [31:0] x, logic [31:0] y, logic [63:0] p);
    start = 1; is_signed = sgn; a = x; b = y;
    q.push_back('{p, cyc + 1 + 33});
    @(negedge clk);
    start = 0; a = $urandom; b = $urandom; is_signed = 1'($urandom);
    check("busy_after_start", 64'(busy), 64'd1);
  endtask

  task automatic wait_done();
    int n = 0;
    while (!done && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("done_seen", 64'(done), 64'd1);
    check("busy_in_done", 64'(busy), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bit s;
    logic [31:0] x, y;
    #12;
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_hi", 64'(hi), 64'd0);
    check("rst_lo", 64'(lo), 64'd0);
    @(negedge clk);
    reset = 0;
    issue(0, 32'd7, 32'd6, 64'h0000_0000_0000_002a);
    wait_done();
    issue(1, 32'hffff_fffd, 32'd5, 64'hffff_ffff_ffff_fff1);
    wait_done();
    issue(0, 32'hffff_fffd, 32'd5, 64'h0000_0004_ffff_fff1);
    wait_done();
    issue(0, 32'hffff_ffff, 32'hffff_ffff, 64'hffff_fffe_0000_0001);
    wait_done();
    issue(1, 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000);
    wait_done();
    // start and mthi mid-run are both ignored
    @(negedge clk);
    issue(0, 32'h0000_1234, 32'h0000_0010, 64'h0000_0000_0001_2340);
    repeat (9) @(negedge clk);
    start = 1; a = 32'h9; b = 32'h9; wr_hi = 1; wdata = 32'h1234_5678;
    @(negedge clk);
    start = 0; wr_hi = 0;
    wait_done();
    repeat (40) @(negedge clk);
    check("hold_hi", 64'(hi), 64'h0);
    check("hold_lo", 64'(lo), 64'h0001_2340);
    // reset mid-run aborts with no done pulse
    issue(1, 32'hffff_fff0, 32'h0000_0123, model(1, 32'hffff_fff0, 32'h0000_0123));
    repeat (9) @(negedge clk);
    #2 reset = 1;
    #1;
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_hi", 64'(hi), 64'd0);
    check("abort_lo", 64'(lo), 64'd0);
    q.delete();
    @(negedge clk);
    reset = 0;
    repeat (40) @(negedge clk);
    check("post_abort_hi", 64'(hi), 64'd0);
    check("post_abort_lo", 64'(lo), 64'd0);
    // mthi/mtlo in IDLE, then both together
    wr_hi = 1; wdata = 32'hcafe_babe;
    @(negedge clk);
    wr_hi = 0; wr_lo = 1; wdata = 32'h0000_0001;
    @(negedge clk);
    wr_lo = 0;
    check("mthi", 64'(hi), 64'hcafe_babe);
    check("mtlo", 64'(lo), 64'h1);
    wr_hi = 1; wr_lo = 1; wdata = 32'h5a5a_a5a5;
    @(negedge clk);
    wr_hi = 0; wr_lo = 0;
    check("mtboth", {hi, lo}, 64'h5a5a_a5a5_5a5a_a5a5);
    // back-to-back starts issued in the done cycle
    issue(0, 32'd100, 32'd200, 64'd20000);
    wait_done();
    issue(1, 32'hffff_ffff, 32'd3, 64'hffff_ffff_ffff_fffd);
    wait_done();
    for (int i = 0; i < 24; i++) begin
      s = 1'($urandom);
      x = pick();
      y = pick();
      issue(s, x, y, model(s, x, y));
      repeat ($urandom_range(0, 20)) begin
        @(negedge clk);
        wr_hi = 1'($urandom); wr_lo = 1'($urandom); wdata = $urandom;
      end
      wr_hi = 0; wr_lo = 0;
      wait_done();
      if ($urandom_range(0, 1) == 1) repeat ($urandom_range(1, 3)) @(negedge clk);
    end
    repeat (40) @(negedge clk);
    check("scoreboard_empty", 64'(q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end
endmodule
